// File: rtl/ccff_chain_readback.sv
// Serial readback of the configuration chain: the tail bit is recirculated into the head and
// packed LSB-first into WORD_W-bit words on a valid/ready stream.
module ccff_chain_readback #(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StOut, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              pass_last;

  assign pass_last = (bit_cnt_q == CNT_W'(CHAIN_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      pack_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      pack_q    <= pack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    pack_d    = pack_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StShift;
          idx_d     = '0;
          bit_cnt_d = '0;
          pack_d    = '0;
        end
      end
      StShift: begin
        // Tail is sampled before this edge's shift, so bit 0 of the chain lands in rd_data[0].
        pack_d    = pack_q | (WORD_W'(ccff_tail) << idx_q);
        idx_d     = idx_q + 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if ((idx_q == IdxW'(WORD_W - 1)) || (bit_cnt_q == CNT_W'(CHAIN_LEN - 1))) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (rd_ready) begin
          if (pass_last) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
            idx_d   = '0;
            pack_d  = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ccff_head     = ccff_tail;
  assign ccff_shift_en = (state_q == StShift);
  assign rd_valid      = (state_q == StOut);
  assign rd_last       = (state_q == StOut) && pass_last;
  assign rd_data       = pack_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_ccff_chain_readback.sv
// Directed bench: two readback instances (20/8 and 16/8) each beside a recirculating chain model.
module tb_ccff_chain_readback;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic rd_ready = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  // Instance A: CHAIN_LEN=20, WORD_W=8
  logic        tail_a, head_a, shift_a, valid_a, last_a, busy_a, done_a;
  logic [7:0]  data_a;
  logic [19:0] chain_a;
  logic        load_a = 1'b0;
  logic [19:0] load_val_a = '0;

  ccff_chain_readback #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .start         (start && !sel),
    .ccff_tail     (tail_a),
    .ccff_head     (head_a),
    .ccff_shift_en (shift_a),
    .rd_data       (data_a),
    .rd_valid      (valid_a),
    .rd_ready      (rd_ready),
    .rd_last       (last_a),
    .busy          (busy_a),
    .done          (done_a)
  );

  assign tail_a = chain_a[0];
  always @(posedge clk) begin
    if (load_a) chain_a <= load_val_a;
    else if (shift_a) chain_a <= {head_a, chain_a[19:1]};
  end

  // Instance B: CHAIN_LEN=16, WORD_W=8
  logic        tail_b, head_b, shift_b, valid_b, last_b, busy_b, done_b;
  logic [7:0]  data_b;
  logic [15:0] chain_b;
  logic        load_b = 1'b0;
  logic [15:0] load_val_b = '0;

  ccff_chain_readback #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .start         (start && sel),
    .ccff_tail     (tail_b),
    .ccff_head     (head_b),
    .ccff_shift_en (shift_b),
    .rd_data       (data_b),
    .rd_valid      (valid_b),
    .rd_ready      (rd_ready),
    .rd_last       (last_b),
    .busy          (busy_b),
    .done          (done_b)
  );

  assign tail_b = chain_b[0];
  always @(posedge clk) begin
    if (load_b) chain_b <= load_val_b;
    else if (shift_b) chain_b <= {head_b, chain_b[15:1]};
  end

  // Observation mux so one pass runner serves both instances.
  logic       o_shift, o_valid, o_last, o_busy, o_done;
  logic [7:0] o_data;
  assign o_shift = sel ? shift_b : shift_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_data  = sel ? data_b  : data_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] words[$];
  logic       lasts[$];
  int         shifts, dones, first_valid_cyc;
  logic       busy_at0, stall_bad;

  function automatic logic [8:0] word_at(input int i);
    if (i < words.size()) return {lasts[i], words[i]};
    return 9'h1ff;
  endfunction

  task automatic load_chain(input logic [19:0] val);
    @(negedge clk);
    if (sel) begin load_b = 1'b1; load_val_b = val[15:0]; end
    else begin load_a = 1'b1; load_val_a = val; end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Pulses start, then observes 60 cycles. Optional stall on word 0 and extra start pulses.
  task automatic run_pass(input int stall, input int restart0, input int restart1);
    int stall_cnt;
    words.delete();
    lasts.delete();
    shifts = 0;
    dones = 0;
    first_valid_cyc = -1;
    stall_bad = 1'b0;
    stall_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_at0 = o_busy;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (o_valid && words.size() == 0 && stall_cnt < stall) begin
        rd_ready = 1'b0;
        stall_cnt++;
        if (o_data !== 8'hA5 || o_shift !== 1'b0) stall_bad = 1'b1;
      end else begin
        rd_ready = 1'b1;
      end
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid && rd_ready) begin
        words.push_back(o_data);
        lasts.push_back(o_last);
      end
      if (o_shift) shifts++;
      if (o_done) dones++;
      start = (cyc == restart0 || cyc == restart1);
      @(negedge clk);
    end
    start = 1'b0;
    rd_ready = 1'b1;
  endtask

  task automatic check_pass20(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2);
    check_eq({tag, "_nwords"}, words.size(), 3);
    check_eq({tag, "_w0"}, word_at(0), {1'b0, w0});
    check_eq({tag, "_w1"}, word_at(1), {1'b0, w1});
    check_eq({tag, "_w2"}, word_at(2), {1'b1, w2});
    check_eq({tag, "_shifts"}, shifts, 20);
    check_eq({tag, "_dones"}, dones, 1);
  endtask

  initial begin
    #12;
    check_eq("rst_shift_en", shift_a, 0);
    check_eq("rst_rd_valid", valid_a, 0);
    check_eq("rst_rd_last", last_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_rd_data", data_a, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic pass with latency checks
    load_chain(20'h53CA5);
    run_pass(0, -1, -1);
    check_pass20("t1", 8'hA5, 8'h3C, 8'h05);
    check_eq("t1_restored", chain_a, 20'h53CA5);
    check_eq("t6_busy_after_e0", busy_at0, 1);
    check_eq("t6_first_valid", first_valid_cyc, 8);

    // Backpressure on the first word
    run_pass(10, -1, -1);
    check_pass20("t2", 8'hA5, 8'h3C, 8'h05);
    check_eq("t2_stall_stable", stall_bad, 0);
    check_eq("t2_restored", chain_a, 20'h53CA5);

    // Start pulses during a pass are ignored
    run_pass(0, 3, 15);
    check_pass20("t3", 8'hA5, 8'h3C, 8'h05);
    check_eq("t3_idle_after", busy_a, 0);

    // Async reset after 5 shifts leaves the chain rotated by 5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("t4_outs_zero", {shift_a, valid_a, last_a, busy_a, done_a, data_a}, 0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("t4_chain_rot", chain_a, 20'h2A9E5);
    run_pass(0, -1, -1);
    check_pass20("t4", 8'hE5, 8'hA9, 8'h02);

    // CHAIN_LEN a multiple of WORD_W
    sel = 1'b1;
    load_chain(20'h0BEEF);
    run_pass(0, -1, -1);
    check_eq("t5_nwords", words.size(), 2);
    check_eq("t5_w0", word_at(0), {1'b0, 8'hEF});
    check_eq("t5_w1", word_at(1), {1'b1, 8'hBE});
    check_eq("t5_shifts", shifts, 16);
    check_eq("t5_dones", dones, 1);
    check_eq("t5_restored", chain_b, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
